// File: rtl/booth_radix4_digit_encoder_if.sv
// Operand-in / Booth-digit-out handshake bundle for the radix-4 Booth encoder.
// The slave modport is the encoder side; the master modport is the operand source and digit consumer.
interface booth_radix4_digit_encoder_if #(
  parameter int Data_Width = 8
);
  localparam int ND = Data_Width / 2;
  localparam int IW = ($clog2(ND) > 1) ? $clog2(ND) : 1;

  logic                  In_Valid;
  logic                  In_Ready;
  logic [Data_Width-1:0] Multiplier;
  logic                  Out_Valid;
  logic                  Out_Ready;
  logic                  Shift;
  logic                  Negation;
  logic                  Zero;
  logic [IW-1:0]         Digit_Index;
  logic                  Last;

  modport slave (
    input  In_Valid, Multiplier, Out_Ready,
    output In_Ready, Out_Valid, Shift, Negation, Zero, Digit_Index, Last
  );

  modport master (
    output In_Valid, Multiplier, Out_Ready,
    input  In_Ready, Out_Valid, Shift, Negation, Zero, Digit_Index, Last
  );
endinterface

// File: rtl/booth_radix4_digit_encoder.sv
// Sequential radix-4 Booth encoder: captures one signed multiplier and emits one
// {Shift, Negation, Zero} digit per accepted cycle, least-significant digit first.
module booth_radix4_digit_encoder #(
  parameter int Data_Width = 8
) (
  input logic                          clk,
  input logic                          rst,
  booth_radix4_digit_encoder_if.slave  bus
);
  localparam int ND = Data_Width / 2;
  localparam int IW = ($clog2(ND) > 1) ? $clog2(ND) : 1;

  typedef enum logic {IDLE, ENCODE} state_t;

  state_t                       state, state_n;
  logic signed [Data_Width:0]   op_p0, op_n;
  logic        [IW-1:0]         idx_p0, idx_n;
  logic                         shift_p0, neg_p0, zero_p0, last_p0;
  logic        [2:0]            trip;
  logic        [2:0]            sel_n;
  logic                         last_n, fire, in_ready, take_in;

  // Returns {Shift, Negation, Zero}; 000 and 111 both map to a plain zero digit.
  function automatic logic [2:0] booth_sel(input logic [2:0] t);
    case (t)
      3'b000, 3'b111: booth_sel = 3'b001;
      3'b001, 3'b010: booth_sel = 3'b000;
      3'b011:         booth_sel = 3'b100;
      3'b100:         booth_sel = 3'b110;
      default:        booth_sel = 3'b010;
    endcase
  endfunction

  always_comb begin
    fire     = (state == ENCODE) & bus.Out_Ready;
    in_ready = (state == IDLE) | (fire & last_p0);
    take_in  = bus.In_Valid & in_ready;
    state_n  = state;
    op_n     = op_p0;
    idx_n    = idx_p0;
    if (take_in) begin
      state_n = ENCODE;
      op_n    = {bus.Multiplier, 1'b0};
      idx_n   = '0;
    end else if (fire && last_p0) begin
      state_n = IDLE;
      idx_n   = '0;
    end else if (fire) begin
      idx_n   = idx_p0 + IW'(1);
    end
    // The next digit is decoded ahead of the edge so the outputs come straight from flops.
    trip = '0;
    for (int i = 0; i < ND; i++) begin
      if (idx_n == IW'(i)) trip = op_n[2*i +: 3];
    end
    sel_n  = (state_n == ENCODE) ? booth_sel(trip) : 3'b000;
    last_n = (state_n == ENCODE) && (idx_n == IW'(ND - 1));
  end

  // Stage p0: held operand (data path, no reset)
  always_ff @(posedge clk) begin
    op_p0 <= op_n;
  end

  // Stage p0: control state and registered digit outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx_p0   <= '0;
      shift_p0 <= 1'b0;
      neg_p0   <= 1'b0;
      zero_p0  <= 1'b0;
      last_p0  <= 1'b0;
    end else begin
      state    <= state_n;
      idx_p0   <= idx_n;
      shift_p0 <= sel_n[2];
      neg_p0   <= sel_n[1];
      zero_p0  <= sel_n[0];
      last_p0  <= last_n;
    end
  end

  assign bus.In_Ready    = in_ready;
  assign bus.Out_Valid   = (state == ENCODE);
  assign bus.Shift       = shift_p0;
  assign bus.Negation    = neg_p0;
  assign bus.Zero        = zero_p0;
  assign bus.Digit_Index = idx_p0;
  assign bus.Last        = last_p0;
endmodule

// File: tb/tb_booth_radix4_digit_encoder.sv
// Directed bench for the radix-4 Booth digit encoder with hand-derived digit tables.
// Digits are written as {Shift, Negation, Zero}: Z=001, +1=000, -1=010, +2=100, -2=110.
module tb_booth_radix4_digit_encoder;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  booth_radix4_digit_encoder_if #(.Data_Width(8)) bus ();

  booth_radix4_digit_encoder #(.Data_Width(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] digit();
    return {bus.Shift, bus.Negation, bus.Zero};
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_vld"}, bus.Out_Valid, 1'b0);
    chk({tag, "_rdy"}, bus.In_Ready, 1'b1);
    chk({tag, "_dig"}, digit(), 3'b000);
    chk({tag, "_idx"}, bus.Digit_Index, 2'd0);
    chk({tag, "_last"}, bus.Last, 1'b0);
  endtask

  // exp holds digit i in bits [3i+2:3i]; Out_Ready is held at 1.
  task automatic run_op(input string tag, input logic [7:0] op, input logic [11:0] exp);
    bus.Out_Ready  = 1'b1;
    bus.In_Valid   = 1'b1;
    bus.Multiplier = op;
    tick();
    bus.In_Valid   = 1'b0;
    bus.Multiplier = ~op;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_vld%0d", tag, i), bus.Out_Valid, 1'b1);
      chk($sformatf("%s_dig%0d", tag, i), digit(), exp[3*i +: 3]);
      chk($sformatf("%s_idx%0d", tag, i), bus.Digit_Index, i[1:0]);
      chk($sformatf("%s_last%0d", tag, i), bus.Last, (i == 3));
      tick();
    end
    chk_idle({tag, "_end"});
  endtask

  initial begin
    logic [11:0] e5a;
    logic [11:0] e07;
    logic [11:0] e80;
    logic [3:0]  rdy_pat;
    int          d;
    int          k;
    errors = 0;
    checks = 0;
    e07 = {3'b001, 3'b001, 3'b100, 3'b010};
    e80 = {3'b110, 3'b001, 3'b001, 3'b001};
    e5a = {3'b000, 3'b100, 3'b010, 3'b110};
    rdy_pat = 4'b1001;

    rst = 1'b1;
    bus.In_Valid = 1'b0;
    bus.Multiplier = 8'h00;
    bus.Out_Ready = 1'b0;
    tick();
    tick();
    chk_idle("reset");
    rst = 1'b0;
    tick();
    chk_idle("post_reset");

    run_op("zero", 8'h00, {3'b001, 3'b001, 3'b001, 3'b001});
    run_op("pos7", 8'h07, e07);
    run_op("min", 8'h80, e80);
    run_op("neg1", 8'hFF, {3'b001, 3'b001, 3'b001, 3'b010});

    // Backpressure: a competing operand is offered while stalled and must be ignored.
    bus.Out_Ready  = 1'b0;
    bus.In_Valid   = 1'b1;
    bus.Multiplier = 8'h5A;
    tick();
    bus.Multiplier = 8'h07;
    d = 0;
    k = 0;
    while (d < 4 && k < 20) begin
      bus.Out_Ready = rdy_pat[k % 4];
      bus.In_Valid  = (d < 3);
      #1;
      chk($sformatf("bp_vld_k%0d", k), bus.Out_Valid, 1'b1);
      chk($sformatf("bp_dig_k%0d", k), digit(), e5a[3*d +: 3]);
      chk($sformatf("bp_idx_k%0d", k), bus.Digit_Index, d[1:0]);
      chk($sformatf("bp_last_k%0d", k), bus.Last, (d == 3));
      if (bus.Out_Ready) d++;
      k++;
      tick();
    end
    chk("bp_done", d, 4);
    bus.In_Valid = 1'b0;
    bus.Out_Ready = 1'b1;
    #1;
    chk_idle("bp_end");

    // Back-to-back: 0x80 is taken on the same edge as the last digit of 0x07.
    bus.Out_Ready  = 1'b1;
    bus.In_Valid   = 1'b1;
    bus.Multiplier = 8'h07;
    tick();
    bus.Multiplier = 8'h80;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        bus.In_Valid   = 1'b0;
        bus.Multiplier = 8'h33;
        #1;
      end
      chk($sformatf("b2b_vld%0d", i), bus.Out_Valid, 1'b1);
      chk($sformatf("b2b_dig%0d", i), digit(), (i < 4) ? e07[3*i +: 3] : e80[3*(i-4) +: 3]);
      chk($sformatf("b2b_idx%0d", i), bus.Digit_Index, i[1:0]);
      chk($sformatf("b2b_rdy%0d", i), bus.In_Ready, (i == 3) || (i == 7));
      tick();
    end
    chk_idle("b2b_end");

    // Reset while digit 1 of 0x07 is on the outputs.
    bus.In_Valid   = 1'b1;
    bus.Multiplier = 8'h07;
    tick();
    bus.In_Valid   = 1'b0;
    tick();
    chk("rstmid_dig1", digit(), 3'b100);
    chk("rstmid_idx1", bus.Digit_Index, 2'd1);
    rst = 1'b1;
    #1;
    chk_idle("rstmid_async");
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rstmid_quiet%0d", i), bus.Out_Valid, 1'b0);
    end
    run_op("after_rst", 8'h5A, e5a);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/booth_radix4_digit_encoder.md
# booth_radix4_digit_encoder

Sequential radix-4 Booth encoder that produces the `{Shift, Negation, Zero}` select triplets consumed by the Booth partial-product sub-module of the MAC unit. It accepts one signed multiplier operand through a valid/ready handshake. It then emits one Booth digit per cycle, least-significant first, through a second valid/ready handshake, with digit index and last-digit flag. It is the multiplier-side front end of the iterative MAC datapath.

## Interface
- `Data_Width`, 8: multiplier width in bits. Must be even and ≥ 4. Digit count `ND = Data_Width/2`.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `In_Valid` input 1: operand offered.
- `In_Ready` output 1: encoder can accept an operand.
- `Multiplier` input `Data_Width`: signed two's-complement operand. Captured on the handshake.
- `Out_Valid` output 1: digit outputs valid.
- `Out_Ready` input 1: consumer accepts the digit.
- `Shift` output 1: digit magnitude is 2.
- `Negation` output 1: digit is negative.
- `Zero` output 1: digit is 0.
- `Digit_Index` output `max(1,$clog2(ND))`: index i of the current digit. Its weight is 4^i.
- `Last` output 1: the current digit is index ND-1.

## Operation
- States:
  - IDLE: no operand held.
  - ENCODE: operand held, digits being emitted.
- Input handshake: the transfer happens when `In_Valid & In_Ready` at a rising edge.
  - `In_Ready` = (state == IDLE) | (`Out_Valid & Out_Ready & Last`). This is combinational and allows back-to-back operands.
- On input transfer:
  - Register the operand with an appended LSB 0, forming `{Multiplier, 1'b0}`.
  - Set `Digit_Index`=0 and `Out_Valid`=1. Go to ENCODE.
- Digit i is decoded from the triplet `{b[2i+1], b[2i], b[2i-1]}`, with b[-1]=0:
  - 000 → Zero=1, Shift=0, Negation=0
  - 001, 010 → +1: 0,0,0
  - 011 → +2: Shift=1
  - 100 → −2: Shift=1, Negation=1
  - 101, 110 → −1: Negation=1
  - 111 → Zero=1, Shift=0, Negation=0. Negative zero is never emitted.
- Whenever Zero=1, Shift and Negation are 0.
- Digit outputs are registered. They are decoded from the held operand at `Digit_Index`.
- Output handshake: a digit transfers when `Out_Valid & Out_Ready`.
  - Not Last: increment `Digit_Index`. The next digit is presented in the following cycle, with `Out_Valid` staying 1.
  - Last with a new input transfer in the same cycle: load the new operand and present its digit 0 in the next cycle. There is no bubble.
  - Last with no input transfer: `Out_Valid`→0. Go to IDLE.
- Backpressure: while `Out_Valid & !Out_Ready`, all digit outputs, `Digit_Index` and `Last` hold stable. `In_Valid` is ignored.
- `Multiplier` changes after capture have no effect.
- Reset, at any time including mid-operand: abandon the operand. No further digits of it are emitted.
- Sum over i of digit_i·4^i equals the signed value of `Multiplier` for every input, including the most negative value.

## Timing
- Reset values:
  - state IDLE
  - `Out_Valid`=0, `Shift`=0, `Negation`=0, `Zero`=0, `Digit_Index`=0, `Last`=0
  - `In_Ready`=1
- Latency: input transfer at edge N → digit 0 valid after edge N, visible in cycle N+1.
- Throughput: ND cycles per operand with `Out_Ready` held at 1. Back-to-back operands are sustained with no idle cycle.
- `Last` is asserted combinationally with `Digit_Index == ND-1` while `Out_Valid`=1. It is registered alongside the digit.
- No combinational path from `In_Valid` or `Multiplier` to any output.
- `Out_Ready` reaches only `In_Ready`.

## Test plan
- **Zero operand.** Reset, `Multiplier`=8'h00 → 4 digits, all Zero=1, indices 0..3, `Last` only on index 3. Then `Out_Valid`=0 and `In_Ready`=1.
- **Positive value.** 8'h07 → digit0 = −1 (N=1), digit1 = +2 (S=1), digit2 Zero, digit3 Zero. The weighted sum is 7.
- **Most negative and −1.**
  - 8'h80 → digits 0–2 Zero, digit3 = −2 (S=1, N=1).
  - 8'hFF → digit0 = −1, digits 1–3 Zero. No triplet 111 ever yields N=1.
- **Backpressure.** Operand 8'h5A with `Out_Ready` toggling 1,0,0,1,… → each digit holds stable while stalled. The exact sequence of 4 digits and indices is delivered once each.
- **Back-to-back.** `In_Valid` held high with operands 8'h07 then 8'h80, `Out_Ready`=1 → 8 consecutive valid cycles. The second operand's digit0 follows the first operand's `Last` with no gap.
- **Reset mid-operand.** Assert `rst` after digit 1 of 8'h07 → all outputs return to their reset values immediately. No remaining digits appear after release, and a new operand encodes correctly.
